// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its buffers.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned PC_STEP      = 4;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [INSTR_W-1:0]      instr;
    } fetch_entry_t;

    // Bits needed to hold an occupancy count from 0 up to and including depth.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush and an occupancy count; read data
// is the current head, valid whenever empty_o is low.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        // NOTE: combinational logic uses blocking '=', registers use '<=' so every flop samples pre-edge values.
        // NOTE: every *_d gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which slots hold live data.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order memory
// requests, drops responses made stale by a redirect, and buffers {pc, instr}.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    output logic               imem_req_valid_o,
    input  logic               imem_req_ready_i,
    output logic [XLEN-1:0]    imem_req_addr_o,
    input  logic               imem_rsp_valid_i,
    input  logic [INSTR_W-1:0] imem_rsp_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [XLEN-1:0]    out_pc_o,
    output logic [INSTR_W-1:0] out_instr_o
);

    localparam int unsigned CW = cnt_w(BUF_DEPTH);
    localparam int unsigned OW = CW + 2;

    // Same layout as fetch_entry_t, but sized by this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [XLEN-1:0] pcq_head;
    logic [CW-1:0]   pcq_count, ibuf_count;
    logic            pcq_empty, pcq_full, ibuf_empty, ibuf_full;
    entry_t          ibuf_wdata, ibuf_rdata;

    logic [OW-1:0]   occupancy;
    logic            req_fire, rsp_stale, rsp_take, out_fire;

    // Every slot is either awaiting a response (live or stale) or holding an instruction.
    assign occupancy = OW'(pcq_count) + OW'(drop_q) + OW'(ibuf_count);

    assign imem_req_valid_o = !rst && !redirect_valid_i && (occupancy < OW'(BUF_DEPTH));
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    assign rsp_stale = imem_rsp_valid_i && (redirect_valid_i || (drop_q != '0));
    assign rsp_take  = imem_rsp_valid_i && !rsp_stale;

    assign out_valid_o = !ibuf_empty;
    assign out_fire    = out_valid_o && out_ready_i;
    assign out_pc_o    = ibuf_empty ? '0 : ibuf_rdata.pc;
    assign out_instr_o = ibuf_empty ? '0 : ibuf_rdata.instr;

    assign ibuf_wdata.pc    = pcq_head;
    assign ibuf_wdata.instr = imem_rsp_data_i;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
        end else if (req_fire) begin
            pc_d = pc_q + XLEN'(PC_STEP);
        end
    end

    // On redirect every unanswered request becomes stale; a response arriving
    // in that cycle already answers the oldest one.
    always_comb begin
        drop_d = drop_q;
        if (redirect_valid_i) begin
            drop_d = drop_q + pcq_count - CW'(imem_rsp_valid_i);
        end else if (imem_rsp_valid_i && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_pc_queue (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid_i),
        .push_i  (req_fire),
        .wdata_i (pc_q),
        .pop_i   (rsp_take),
        .rdata_o (pcq_head),
        .empty_o (pcq_empty),
        .full_o  (pcq_full),
        .count_o (pcq_count)
    );

    // A handshake in a redirect cycle still pops; the flush then clears the rest.
    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_instr_buf (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid_i),
        .push_i  (rsp_take),
        .wdata_i (ibuf_wdata),
        .pop_i   (out_fire),
        .rdata_o (ibuf_rdata),
        .empty_o (ibuf_empty),
        .full_o  (ibuf_full),
        .count_o (ibuf_count)
    );

    rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid_i |-> ((drop_q != '0) || !pcq_empty));

    pcq_no_overflow: assert property (@(posedge clk) disable iff (rst)
        req_fire |-> !pcq_full);

    ibuf_no_overflow: assert property (@(posedge clk) disable iff (rst)
        rsp_take |-> !ibuf_full);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: in-order memory model with random latency,
// expected-stream scoreboard and an independent credit/occupancy model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .imem_req_valid_o (imem_req_valid),
        .imem_req_ready_i (imem_req_ready),
        .imem_req_addr_o  (imem_req_addr),
        .imem_rsp_valid_i (imem_rsp_valid),
        .imem_rsp_data_i  (imem_rsp_data),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_pc_o         (out_pc),
        .out_instr_o      (out_instr)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } mem_req_t;

    mem_req_t     mem_q[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  track_q[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          hits = 0;
    int          n_out = 0;
    logic [31:0] model_pc = RST_PC;
    bit          flush_prev = 0;
    bit          hold_prev = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, account for the cycle after the falling edge.
    task automatic step(input bit rst_v, input bit rdr_in, input logic [31:0] tgt,
                        input bit mready, input bit oready, input bit auto_rdr);
        int live_n, occ, due, lat;
        bit rdr, rsp_live, want_req;
        @(posedge clk);
        #1;
        live_n = 0;
        foreach (mem_q[i]) if (mem_q[i].live) live_n++;
        occ = mem_q.size() + exp_q.size() - live_n;
        rdr = rdr_in;
        rsp_live = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        if (!rst_v && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = instr_of(mem_q[0].addr);
            rsp_live = mem_q[0].live;
            void'(mem_q.pop_front());
        end
        if (auto_rdr && rsp_live && out_valid && oready) begin
            rdr = 1'b1;
            hits++;
        end
        rst = rst_v;
        redirect_valid = rdr;
        redirect_pc = tgt;
        imem_req_ready = mready;
        out_ready = oready;
        want_req = !rst_v && !rdr && (occ < DEPTH);

        @(negedge clk);
        #1;
        check("req_valid", imem_req_valid, want_req);
        if (rst_v) begin
            mem_q.delete();
            exp_q.delete();
            model_pc = RST_PC;
            last_due = 0;
        end else if (rdr) begin
            foreach (mem_q[i]) mem_q[i].live = 1'b0;
            exp_q.delete();
            model_pc = {tgt[31:2], 2'b00};
        end else if (imem_req_valid && mready) begin
            check("req_addr", imem_req_addr, model_pc);
            exp_q.push_back('{pc: model_pc, instr: instr_of(model_pc)});
            lat = $urandom_range(lat_hi, lat_lo);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: imem_req_addr, due: due, live: 1'b1});
            model_pc = model_pc + 32'd4;
        end
    endtask

    // Scoreboard monitor: compares every delivered instruction against the expected stream.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (flush_prev) check("valid_after_flush", out_valid, 1'b0);
            else if (hold_prev) check("valid_held", out_valid, 1'b1);
            if (out_valid && out_ready && !rst) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got pc %0h want no output", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", out_instr, e.instr);
                    if (track_q.size() != 0) check("directed_pc", out_pc, track_q.pop_front());
                end
            end
            flush_prev = rst || redirect_valid;
            hold_prev = out_valid && !out_ready && !rst && !redirect_valid;
        end
    end

    initial begin
        int n0;
        bit r, rd;
        logic [31:0] tgt;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        out_ready = 1'b0;

        // Reset state
        step(1, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_req_addr", imem_req_addr, RST_PC);

        // Streaming from RESET_PC, latency 1, decode always ready
        track_q.push_back(RST_PC);
        track_q.push_back(RST_PC + 32'd4);
        track_q.push_back(RST_PC + 32'd8);
        n0 = n_out;
        for (int k = 0; k < 30; k++) step(0, 0, 0, 1, 1, 0);
        check("stream_rate_ok", (n_out - n0) >= 16, 1'b1);

        // Backpressure: buffer fills to exactly BUF_DEPTH and requests stop
        for (int k = 0; k < 12; k++) step(0, 0, 0, 1, 0, 0);
        check("stall_buffered", exp_q.size(), DEPTH);
        check("stall_req_valid", imem_req_valid, 1'b0);
        check("stall_out_valid", out_valid, 1'b1);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 1, 1, 0);

        // Redirect with two requests outstanding
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 1, 0);
        lat_lo = 3;
        lat_hi = 3;
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        check("two_outstanding", mem_q.size(), 2);
        step(0, 1, 32'h0000_2003, 1, 1, 0);
        track_q.push_back(32'h0000_2000);
        step(0, 0, 0, 1, 1, 0);
        check("redirect_addr", imem_req_addr, 32'h0000_2000);
        for (int k = 0; k < 20; k++) step(0, 0, 0, 1, 1, 0);
        check("redirect_delivered", track_q.size(), 0);

        // Redirect coinciding with a live response and an output handshake
        lat_lo = 1;
        lat_hi = 1;
        for (int k = 0; k < 60 && hits == 0; k++) step(0, 0, 32'h0000_3000, 1, 1, 1);
        check("coincide_seen", hits, 1);
        track_q.push_back(32'h0000_3000);
        for (int k = 0; k < 12; k++) step(0, 0, 0, 1, 1, 0);

        // PC wrap-around
        step(0, 1, 32'hFFFF_FFFC, 1, 1, 0);
        track_q.push_back(32'hFFFF_FFFC);
        track_q.push_back(32'h0000_0000);
        for (int k = 0; k < 12; k++) step(0, 0, 0, 1, 1, 0);
        check("wrap_delivered", track_q.size(), 0);

        // Reset mid-stream with a full buffer
        for (int k = 0; k < 8; k++) step(0, 0, 0, 1, 0, 0);
        check("full_before_rst", exp_q.size(), DEPTH);
        step(1, 0, 0, 1, 1, 0);
        track_q.push_back(RST_PC);
        step(0, 0, 0, 1, 1, 0);
        check("restart_addr", imem_req_addr, RST_PC);
        for (int k = 0; k < 12; k++) step(0, 0, 0, 1, 1, 0);
        check("restart_delivered", track_q.size(), 0);

        // Random traffic: latency, readiness, redirects, occasional reset
        lat_lo = 1;
        lat_hi = 3;
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(399, 0) == 0);
            rd = !r && ($urandom_range(15, 0) == 0);
            tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
            step(r, rd, tgt, $urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7, 0);
        end

        // Drain: everything issued must be delivered
        for (int k = 0; k < 30; k++) step(0, 0, 0, 0, 1, 0);
        check("drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
